llsc_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one unified_cache_llsc port among NUM_CORES pipeline cores.
- Accepts one transaction at a time, issues it to the cache, and routes the response back to the requester.
- After any completed store (plain write, or SC with success) it broadcasts a snoop invalidate and waits for all other caches to acknowledge.
- Sits between core_pipeline memory stages and the cache/coherence bus.

---
 rtl/llsc_bus_pkg.sv | 15 +
 rtl/llsc_bus_arbiter_if.sv | 66 ++++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/llsc_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_llsc_bus_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/llsc_bus_pkg.sv
// Shared types for the LL/SC bus arbiter.
//   arb_state_t : sequencer states (idle, issue to cache, wait for cache, snoop broadcast)
//   CORE_ID_W   : width of a core index on the cache/coherence bus
package llsc_bus_pkg;

  localparam int unsigned CORE_ID_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitResp,
    StSnoop
  } arb_state_t;

endpackage

// File: rtl/llsc_bus_arbiter_if.sv
// Bundle of core-side, cache-side and snoop-side signals around the arbiter.
//   slave  : arbiter view (drives ready/resp, cache request, snoop broadcast, busy)
//   master : environment view (cores, cache and remote caches)
interface llsc_bus_arbiter_if
  import llsc_bus_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  // Core side
  logic [NUM_CORES-1:0]            core_req_valid;
  logic [NUM_CORES-1:0]            core_req_wr;
  logic [NUM_CORES-1:0]            core_req_atomic;
  logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_req_wdata;
  logic [NUM_CORES-1:0]            core_req_ready;
  logic [NUM_CORES-1:0]            core_resp_valid;
  logic [DATA_WIDTH-1:0]           core_resp_rdata;
  logic                            core_sc_success;
  logic                            core_resp_err;

  // Cache side
  logic                            cache_req_valid;
  logic                            cache_req_wr;
  logic                            cache_req_atomic;
  logic [ADDR_WIDTH-1:0]           cache_req_addr;
  logic [DATA_WIDTH-1:0]           cache_req_wdata;
  logic [CORE_ID_W-1:0]            cache_core_id;
  logic                            cache_busy;
  logic                            cache_resp_valid;
  logic [DATA_WIDTH-1:0]           cache_resp_rdata;
  logic                            cache_sc_success;

  // Coherence side
  logic                            snoop_valid;
  logic [ADDR_WIDTH-1:0]           snoop_addr;
  logic [CORE_ID_W-1:0]            snoop_source_id;
  logic [NUM_CORES-1:0]            snoop_ack;

  logic                            busy;

  modport slave (
    input  core_req_valid, core_req_wr, core_req_atomic, core_req_addr, core_req_wdata,
    output core_req_ready, core_resp_valid, core_resp_rdata, core_sc_success, core_resp_err,
    output cache_req_valid, cache_req_wr, cache_req_atomic, cache_req_addr, cache_req_wdata,
    output cache_core_id,
    input  cache_busy, cache_resp_valid, cache_resp_rdata, cache_sc_success,
    output snoop_valid, snoop_addr, snoop_source_id,
    input  snoop_ack,
    output busy
  );

  modport master (
    output core_req_valid, core_req_wr, core_req_atomic, core_req_addr, core_req_wdata,
    input  core_req_ready, core_resp_valid, core_resp_rdata, core_sc_success, core_resp_err,
    input  cache_req_valid, cache_req_wr, cache_req_atomic, cache_req_addr, cache_req_wdata,
    input  cache_core_id,
    output cache_busy, cache_resp_valid, cache_resp_rdata, cache_sc_success,
    input  snoop_valid, snoop_addr, snoop_source_id,
    output snoop_ack,
    input  busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req_i     : request vector, one bit per core
//   ptr_i     : last granted core; search starts at ptr_i+1 modulo NUM_CORES
//   grant_o   : index of the first requester found
//   any_req_o : at least one request is present
module rr_arbiter
  import llsc_bus_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [CORE_ID_W-1:0] ptr_i,
  output logic [CORE_ID_W-1:0] grant_o,
  output logic                 any_req_o
);

  int unsigned idx;

  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = 0;
    // Offset 1 first, so the previous winner is considered last.
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      idx = (32'(ptr_i) + i) % NUM_CORES;
      if (!any_req_o && req_i[idx]) begin
        any_req_o = 1'b1;
        grant_o   = idx[CORE_ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/llsc_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one LL/SC-capable cache port among NUM_CORES cores.
// One transaction is in flight at a time: grant, issue to cache, return the response to the
// requester, and after a completed store broadcast a snoop invalidate until all other caches ack.
//   clk_i  : clock, all logic on posedge
//   rst_i  : synchronous active-high reset; drops any in-flight transaction silently
//   bus_io : core request/response, cache request/response, snoop and busy signals
module llsc_bus_arbiter
  import llsc_bus_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  llsc_bus_arbiter_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  arb_state_t            state_q;
  logic [CORE_ID_W-1:0]  rr_ptr_q, gnt_q, pick;
  logic                  any_req;
  logic                  wr_q, atomic_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [CntW-1:0]       cnt_q, cnt_inc;
  logic [NUM_CORES-1:0]  ack_q, ready_q, resp_valid_q, src_mask;
  logic                  sc_q, err_q, snoop_valid_q;
  logic                  all_acked, cnt_expired, do_snoop;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES)
  ) u_rr_arbiter (
    .req_i    (bus_io.core_req_valid),
    .ptr_i    (rr_ptr_q),
    .grant_o  (pick),
    .any_req_o(any_req)
  );

  always_comb begin
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
    cnt_expired = (cnt_q == CntW'(TIMEOUT - 1));
    src_mask    = NUM_CORES'(1) << gnt_q;
    // The writer's own ack is masked in; acks arriving this cycle count immediately.
    all_acked   = &(ack_q | bus_io.snoop_ack | src_mask);
    do_snoop    = wr_q && (!atomic_q || bus_io.cache_sc_success);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      rr_ptr_q      <= CORE_ID_W'(NUM_CORES - 1);
      gnt_q         <= '0;
      wr_q          <= 1'b0;
      atomic_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      ack_q         <= '0;
      ready_q       <= '0;
      resp_valid_q  <= '0;
      sc_q          <= 1'b0;
      err_q         <= 1'b0;
      snoop_valid_q <= 1'b0;
    end else begin
      ready_q      <= '0;
      resp_valid_q <= '0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q         <= pick;
            rr_ptr_q      <= pick;
            wr_q          <= bus_io.core_req_wr[pick];
            atomic_q      <= bus_io.core_req_atomic[pick];
            addr_q        <= bus_io.core_req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q       <= bus_io.core_req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
            ready_q[pick] <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          if (!bus_io.cache_busy) begin
            cnt_q   <= '0;
            state_q <= StWaitResp;
          end
        end
        StWaitResp: begin
          if (bus_io.cache_resp_valid) begin
            rdata_q             <= bus_io.cache_resp_rdata;
            sc_q                <= bus_io.cache_sc_success;
            err_q               <= 1'b0;
            resp_valid_q[gnt_q] <= 1'b1;
            if (do_snoop) begin
              snoop_valid_q <= 1'b1;
              ack_q         <= '0;
              cnt_q         <= '0;
              state_q       <= StSnoop;
            end else begin
              state_q <= StIdle;
            end
          end else if (cnt_expired) begin
            rdata_q             <= '0;
            sc_q                <= 1'b0;
            err_q               <= 1'b1;
            resp_valid_q[gnt_q] <= 1'b1;
            state_q             <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StSnoop: begin
          // The core was already answered; a snoop timeout just abandons the broadcast.
          if (all_acked || cnt_expired) begin
            snoop_valid_q <= 1'b0;
            state_q       <= StIdle;
          end else begin
            ack_q <= ack_q | bus_io.snoop_ack;
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // cache_req_valid is combinational on cache_busy so an idle cache sees the request in the
  // first ISSUE cycle.
  assign bus_io.cache_req_valid  = (state_q == StIssue) && !bus_io.cache_busy;
  assign bus_io.cache_req_wr     = wr_q;
  assign bus_io.cache_req_atomic = atomic_q;
  assign bus_io.cache_req_addr   = addr_q;
  assign bus_io.cache_req_wdata  = wdata_q;
  assign bus_io.cache_core_id    = gnt_q;
  assign bus_io.core_req_ready   = ready_q;
  assign bus_io.core_resp_valid  = resp_valid_q;
  assign bus_io.core_resp_rdata  = rdata_q;
  assign bus_io.core_sc_success  = sc_q;
  assign bus_io.core_resp_err    = err_q;
  assign bus_io.snoop_valid      = snoop_valid_q;
  assign bus_io.snoop_addr       = addr_q;
  assign bus_io.snoop_source_id  = gnt_q;
  assign bus_io.busy             = (state_q != StIdle);

endmodule

// File: tb/tb_llsc_bus_arbiter.sv
// Bench for llsc_bus_arbiter. A transaction-level model turns each grant into a timeline
// (ready cycle, issue cycle, response cycle, snoop window, free cycle) from the chosen cache
// busy/latency/ack behaviour, and every cycle the DUT outputs are compared against it.
module tb_llsc_bus_arbiter;
  import llsc_bus_pkg::*;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llsc_bus_arbiter_if #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  llsc_bus_arbiter #(
    .NUM_CORES (NC),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Per-core pending request
  bit          pend[NC];
  bit          p_wr[NC], p_at[NC];
  logic [31:0] p_addr[NC], p_wd[NC];

  // Model timeline of the current transaction
  int          rr = NC - 1;
  int          g = 0, c_free = 0, c_ready = -1, c_issue = -1, c_cresp = -1, c_resp = -1;
  int          snoop_s = -1, snoop_e = -1;
  int          ack_c[NC];
  bit          t_wr, t_at;
  logic [31:0] t_addr, t_wd, cr_data, r_data;
  bit          cr_sc, r_sc, r_err;
  int          r_core = 0;
  bit          post_rst = 0;

  // Knobs (-1 = random)
  int          f_busy = -1, f_delay = -1, f_sc = -1;
  bit          f_rdata_on = 0, f_ack_on = 0;
  logic [31:0] f_rdata = '0;
  int          f_ack[NC];
  bit          rand_req = 0, auto_refill = 0, rst_drv = 1;

  // Observation logs
  int          gnt_log[$], ready_cyc_log[$], resp_core_log[$], resp_cyc_log[$];
  logic [31:0] resp_data_log[$];
  bit          resp_sc_log[$], resp_err_log[$];
  int          creq_cnt = 0, creq_cyc = -1, snoop_cycles = 0, snoop_src_seen = -1;
  logic [31:0] snoop_addr_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit any_pend();
    for (int k = 0; k < NC; k++) if (pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_rr(input int ptr);
    for (int i = 1; i <= NC; i++) if (pend[(ptr + i) % NC]) return (ptr + i) % NC;
    return -1;
  endfunction

  task automatic new_req(input int k, input bit wr, input bit at, input logic [31:0] addr);
    pend[k] = 1'b1; p_wr[k] = wr; p_at[k] = at; p_addr[k] = addr; p_wd[k] = $urandom;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); ready_cyc_log.delete(); resp_core_log.delete(); resp_cyc_log.delete();
    resp_data_log.delete(); resp_sc_log.delete(); resp_err_log.delete();
    creq_cnt = 0; creq_cyc = -1; snoop_cycles = 0; snoop_src_seen = -1; snoop_addr_seen = '0;
  endtask

  task automatic drive();
    logic [NC-1:0] v, w, a, ack;
    logic [NC*AW-1:0] ad;
    logic [NC*DW-1:0] wd;
    for (int k = 0; k < NC; k++) begin
      if (!pend[k] && auto_refill) new_req(k, 1'b0, 1'b0, 32'h1000 + 32'(k * 4));
      if (!pend[k] && rand_req && ($urandom % 3 == 0))
        new_req(k, 1'($urandom), 1'($urandom), 32'($urandom) & 32'h0000_fffc);
      v[k] = pend[k]; w[k] = p_wr[k]; a[k] = p_at[k];
      ad[k*AW +: AW] = p_addr[k];
      wd[k*DW +: DW] = p_wd[k];
      ack[k] = (cyc == ack_c[k]) ||
               (k == g && cyc >= snoop_s && cyc <= snoop_e && 1'($urandom));
    end
    rst                  = rst_drv;
    bus.core_req_valid   = v;
    bus.core_req_wr      = w;
    bus.core_req_atomic  = a;
    bus.core_req_addr    = ad;
    bus.core_req_wdata   = wd;
    bus.cache_busy       = (cyc >= c_ready && cyc < c_issue) ? 1'b1 :
                           (cyc == c_issue) ? 1'b0 : 1'($urandom);
    bus.cache_resp_valid = (cyc == c_cresp);
    bus.cache_resp_rdata = (cyc == c_cresp) ? cr_data : 32'($urandom);
    bus.cache_sc_success = (cyc == c_cresp) ? cr_sc : 1'($urandom);
    bus.snoop_ack        = ack;
  endtask

  task automatic compare();
    bit in_txn, in_snoop;
    in_txn   = (cyc >= c_ready && cyc < c_free);
    in_snoop = (cyc >= snoop_s && cyc <= snoop_e);
    chk("core_req_ready", bus.core_req_ready, (cyc == c_ready) ? 64'(1 << g) : 64'd0);
    chk("cache_req_valid", bus.cache_req_valid, 64'(cyc == c_issue));
    chk("busy", bus.busy, 64'(in_txn));
    if (in_txn) begin
      chk("cache_req_wr", bus.cache_req_wr, 64'(t_wr));
      chk("cache_req_atomic", bus.cache_req_atomic, 64'(t_at));
      chk("cache_req_addr", bus.cache_req_addr, t_addr);
      chk("cache_req_wdata", bus.cache_req_wdata, t_wd);
      chk("cache_core_id", bus.cache_core_id, g);
    end
    chk("core_resp_valid", bus.core_resp_valid, (cyc == c_resp) ? 64'(1 << r_core) : 64'd0);
    if (cyc == c_resp) begin
      chk("core_resp_rdata", bus.core_resp_rdata, r_data);
      chk("core_sc_success", bus.core_sc_success, 64'(r_sc));
      chk("core_resp_err", bus.core_resp_err, 64'(r_err));
    end
    chk("snoop_valid", bus.snoop_valid, 64'(in_snoop));
    if (in_snoop) begin
      chk("snoop_addr", bus.snoop_addr, t_addr);
      chk("snoop_source_id", bus.snoop_source_id, g);
    end
    if (post_rst) begin
      chk("rst_rdata", bus.core_resp_rdata, 0);
      chk("rst_err", bus.core_resp_err, 0);
      chk("rst_sc", bus.core_sc_success, 0);
      chk("rst_cache_addr", bus.cache_req_addr, 0);
      chk("rst_snoop_addr", bus.snoop_addr, 0);
    end
  endtask

  task automatic monitor();
    for (int k = 0; k < NC; k++) begin
      if (bus.core_req_ready[k]) begin gnt_log.push_back(k); ready_cyc_log.push_back(cyc); end
      if (bus.core_resp_valid[k]) begin
        resp_core_log.push_back(k); resp_cyc_log.push_back(cyc);
        resp_data_log.push_back(bus.core_resp_rdata);
        resp_sc_log.push_back(bus.core_sc_success); resp_err_log.push_back(bus.core_resp_err);
      end
    end
    if (bus.cache_req_valid) begin creq_cnt++; creq_cyc = cyc; end
    if (bus.snoop_valid) begin
      snoop_cycles++; snoop_addr_seen = bus.snoop_addr; snoop_src_seen = int'(bus.snoop_source_id);
    end
  endtask

  task automatic schedule(input int c, input int gi);
    int bl, d, off, mx;
    bit all_set;
    g = gi; rr = gi; r_core = gi;
    t_wr = p_wr[gi]; t_at = p_at[gi]; t_addr = p_addr[gi]; t_wd = p_wd[gi];
    c_ready = c + 1;
    bl = (f_busy >= 0) ? f_busy : (($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : 0);
    c_issue = c_ready + bl;
    if (f_delay != -1) d = f_delay;
    else begin
      case ($urandom % 32)
        0: d = -2;
        1: d = TO - 1;
        2: d = TO;
        default: d = int'($urandom_range(0, 4));
      endcase
    end
    snoop_s = -1; snoop_e = -1;
    for (int k = 0; k < NC; k++) ack_c[k] = -1;
    if (d < 0 || d >= TO) begin
      // No response within the 64 WAIT_RESP cycles: error completion.
      c_cresp = (d >= TO) ? c_issue + 1 + d : -1;
      c_resp  = c_issue + 1 + TO;
      r_data = '0; r_sc = 1'b0; r_err = 1'b1;
      c_free = c_resp;
    end else begin
      c_cresp = c_issue + 1 + d;
      c_resp  = c_cresp + 1;
      cr_data = f_rdata_on ? f_rdata : 32'($urandom);
      cr_sc   = (f_sc >= 0) ? 1'(f_sc) : 1'($urandom);
      r_data = cr_data; r_sc = cr_sc; r_err = 1'b0;
      if (t_wr && (!t_at || cr_sc)) begin
        snoop_s = c_resp; mx = 0; all_set = 1'b1;
        for (int k = 0; k < NC; k++) begin
          if (k != gi) begin
            off = f_ack_on ? f_ack[k] : (($urandom % 24 == 0) ? -1 : int'($urandom_range(0, 6)));
            if (off < 0) all_set = 1'b0;
            else begin ack_c[k] = snoop_s + off; if (off > mx) mx = off; end
          end
        end
        snoop_e = all_set ? snoop_s + mx : snoop_s + TO - 1;
        c_free  = snoop_e + 1;
      end else begin
        c_free = c_resp;
      end
    end
  endtask

  task automatic advance();
    int gi;
    if (rst_drv) begin
      c_ready = -1; c_issue = -1; c_cresp = -1; c_resp = -1; snoop_s = -1; snoop_e = -1;
      for (int k = 0; k < NC; k++) ack_c[k] = -1;
      c_free = cyc + 1; rr = NC - 1;
    end else begin
      if (cyc == c_ready) pend[g] = 1'b0;
      if (cyc == c_free) begin
        gi = pick_rr(rr);
        if (gi >= 0) schedule(cyc, gi);
        else c_free = cyc + 1;
      end
    end
    post_rst = rst_drv;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    compare();
    monitor();
    advance();
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b1;
    repeat (n) step();
    rst_drv = 1'b0;
  endtask

  task automatic run_until_idle(input int max, input string name);
    int n = 0;
    while (!(c_free <= cyc + 1 && !any_pend()) && n < max) begin step(); n++; end
    n_tests++;
    if (n >= max) begin
      n_fail++;
      $display("FAIL %s idle wait: got %0d cycles, expected fewer than %0d", name, n, max);
    end
    repeat (2) step();
  endtask

  initial begin
    int q, n;
    int exp2[5];
    exp2 = '{0, 1, 2, 3, 0};
    for (int k = 0; k < NC; k++) begin pend[k] = 0; ack_c[k] = -1; f_ack[k] = -1; end
    bus.core_req_valid = '0; bus.core_req_wr = '0; bus.core_req_atomic = '0;
    bus.core_req_addr = '0; bus.core_req_wdata = '0; bus.cache_busy = 1'b0;
    bus.cache_resp_valid = 1'b0; bus.cache_resp_rdata = '0; bus.cache_sc_success = 1'b0;
    bus.snoop_ack = '0;

    // Single read, idle cache, 1-cycle hit
    do_reset(3);
    clear_logs();
    f_busy = 0; f_delay = 0; f_rdata_on = 1; f_rdata = 32'hDEAD_BEEF;
    new_req(0, 1'b0, 1'b0, 32'h100);
    q = cyc + 1;
    run_until_idle(100, "read");
    chk("read_resp_count", resp_core_log.size(), 1);
    if (resp_core_log.size() > 0) begin
      chk("read_resp_core", resp_core_log[0], 0);
      chk("read_rdata", resp_data_log[0], 32'hDEAD_BEEF);
      chk("read_latency", resp_cyc_log[0] - q, 3);
    end
    if (gnt_log.size() > 0) chk("read_grant", gnt_log[0], 0);
    chk("read_snoop_cycles", snoop_cycles, 0);
    f_rdata_on = 0;

    // All cores requesting continuously
    do_reset(1);
    clear_logs();
    auto_refill = 1;
    n = 0;
    while (gnt_log.size() < 5 && n < 300) begin step(); n++; end
    auto_refill = 0;
    run_until_idle(300, "rr");
    chk("rr_grant_count_ok", 64'(gnt_log.size() >= 5), 1);
    for (int i = 0; i < 5; i++) if (gnt_log.size() > i) chk("rr_order", gnt_log[i], exp2[i]);

    // Successful SC from core 1, acks spread over cycles
    clear_logs();
    f_delay = 1; f_sc = 1; f_ack_on = 1;
    f_ack[0] = 1; f_ack[1] = -1; f_ack[2] = 3; f_ack[3] = 5;
    new_req(1, 1'b1, 1'b1, 32'h40);
    run_until_idle(200, "sc_ok");
    chk("sc_ok_snoop_addr", snoop_addr_seen, 32'h40);
    chk("sc_ok_snoop_src", snoop_src_seen, 1);
    chk("sc_ok_snoop_cycles", snoop_cycles, 6);
    if (resp_sc_log.size() > 0) chk("sc_ok_result", resp_sc_log[0], 1);
    f_ack_on = 0;

    // Failed SC from core 2
    clear_logs();
    f_sc = 0;
    new_req(2, 1'b1, 1'b1, 32'h80);
    run_until_idle(200, "sc_fail");
    chk("sc_fail_resp_count", resp_core_log.size(), 1);
    if (resp_core_log.size() > 0) begin
      chk("sc_fail_core", resp_core_log[0], 2);
      chk("sc_fail_result", resp_sc_log[0], 0);
    end
    chk("sc_fail_snoop_cycles", snoop_cycles, 0);
    f_sc = -1;

    // Cache busy for 5 cycles, then never answers
    clear_logs();
    f_busy = 5; f_delay = -2;
    new_req(0, 1'b0, 1'b0, 32'h200);
    run_until_idle(300, "timeout");
    chk("timeout_issue_count", creq_cnt, 1);
    chk("timeout_resp_count", resp_core_log.size(), 1);
    if (resp_core_log.size() > 0 && ready_cyc_log.size() > 0) begin
      chk("timeout_err", resp_err_log[0], 1);
      chk("timeout_rdata", resp_data_log[0], 0);
      chk("timeout_issue_delay", creq_cyc - ready_cyc_log[0], 5);
      chk("timeout_latency", resp_cyc_log[0] - ready_cyc_log[0], 70);
    end

    // Reset while waiting for the cache
    f_busy = 0; f_delay = 10;
    new_req(3, 1'b0, 1'b0, 32'h300);
    n = 0;
    while (!(c_issue > 0 && cyc == c_issue + 3) && n < 50) begin step(); n++; end
    chk("wait_reached", 64'(n < 50), 1);
    do_reset(1);
    clear_logs();
    f_delay = 0;
    for (int k = 0; k < NC; k++) new_req(k, 1'b0, 1'b0, 32'h400 + 32'(k * 4));
    run_until_idle(200, "post_rst");
    if (gnt_log.size() > 0) chk("post_rst_first_grant", gnt_log[0], 0);
    chk("post_rst_resp_count", resp_core_log.size(), 4);

    // Randomized traffic with occasional resets
    f_busy = -1; f_delay = -1; f_sc = -1;
    rand_req = 1;
    for (int i = 0; i < 3000; i++) begin
      rst_drv = ($urandom % 600 == 0);
      step();
    end
    rst_drv = 0;
    rand_req = 0;
    run_until_idle(3000, "random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
